fault_level_checker: RTL and testbench

- Three-tier spacecraft fault-tolerance gate covering the `level1`, `level2` and `level3` checks in one block.
- Each tier compares a 5-bit subsystem health mask against that tier's failure tolerance and drives a PASSED flag plus five gated subsystem outputs.
- Level 1 is combinational and qualifies raw subsystem requests.
- Levels 2 and 3 are registered stages, armed by operator switches, that sit downstream of Level 1 in the mission sequencer.

---
 rtl/fault_level_checker.sv | 82 ++++++++
 tb/tb_fault_level_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fault_level_checker.sv
// rtl/fault_level_checker.sv - three-tier subsystem fault-tolerance gate (L1 comb, L2/L3 registered)
module fault_level_checker #(
    parameter int NSUB = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSUB-1:0] r,
    input  logic [NSUB-1:0] e1,
    output logic [NSUB-1:0] o1,
    output logic            level1_passed,
    input  logic [NSUB-1:0] e2,
    input  logic            sw2,
    input  logic            l2_off4,
    output logic [NSUB-1:0] o2,
    output logic            level2_passed,
    input  logic [NSUB-1:0] e3,
    input  logic            sw3a,
    input  logic            sw3b,
    input  logic            l3_off3,
    input  logic            l3_off4,
    output logic [NSUB-1:0] o3,
    output logic            level3_passed
);

    function automatic logic [2:0] popcnt(input logic [NSUB-1:0] m);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NSUB; i++) begin
            c = c + {2'b00, m[i]};
        end
        return c;
    endfunction

    logic [NSUB-1:0] o2_d, o2_q;
    logic [NSUB-1:0] o3_d, o3_q;
    logic            level2_passed_d, level2_passed_q;
    logic            level3_passed_d, level3_passed_q;
    logic            arm3;

    assign o1            = r & e1;
    assign level1_passed = (popcnt(e1) >= 3'd4);

    assign arm3 = sw3a | sw3b;

    // Off requests only mask bits after the arm gate; they never touch the verdicts.
    always_comb begin
        level2_passed_d = sw2 & (popcnt(e2) >= 3'd3);
        o2_d            = e2 & {NSUB{sw2}};
        if (l2_off4) begin
            o2_d[1] = 1'b0;
        end

        level3_passed_d = arm3 & (popcnt(e3) >= 3'd2);
        o3_d            = e3 & {NSUB{arm3}};
        if (l3_off3) begin
            o3_d[2] = 1'b0;
        end
        if (l3_off4) begin
            o3_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o2_q            <= '0;
            level2_passed_q <= 1'b0;
            o3_q            <= '0;
            level3_passed_q <= 1'b0;
        end else begin
            o2_q            <= o2_d;
            level2_passed_q <= level2_passed_d;
            o3_q            <= o3_d;
            level3_passed_q <= level3_passed_d;
        end
    end

    assign o2            = o2_q;
    assign level2_passed = level2_passed_q;
    assign o3            = o3_q;
    assign level3_passed = level3_passed_q;

endmodule

// File: tb/tb_fault_level_checker.sv
// tb/tb_fault_level_checker.sv - scoreboard bench for fault_level_checker
module tb_fault_level_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] r, e1, e2, e3;
    logic       sw2, l2_off4, sw3a, sw3b, l3_off3, l3_off4;
    logic [4:0] o1, o2, o3;
    logic       level1_passed, level2_passed, level3_passed;

    typedef struct {
        logic       rst;
        logic [4:0] r, e1, e2, e3;
        logic       sw2, l2_off4, sw3a, sw3b, l3_off3, l3_off4;
    } stim_t;

    typedef struct {
        logic [4:0] o1, o2, o3;
        logic       p1, p2, p3;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event mon_ev;

    fault_level_checker #(.NSUB(5)) dut (
        .clk(clk), .rst(rst),
        .r(r), .e1(e1), .o1(o1), .level1_passed(level1_passed),
        .e2(e2), .sw2(sw2), .l2_off4(l2_off4), .o2(o2), .level2_passed(level2_passed),
        .e3(e3), .sw3a(sw3a), .sw3b(sw3b), .l3_off3(l3_off3), .l3_off4(l3_off4),
        .o3(o3), .level3_passed(level3_passed)
    );

    always #5 clk = ~clk;

    // Reference: tolerance rules applied directly to the sampled inputs.
    function automatic exp_t model(input stim_t s, input bit regs_in_reset);
        exp_t x;
        x.o1 = s.r & s.e1;
        x.p1 = ($countones(s.e1) >= 4);
        if (regs_in_reset) begin
            x.o2 = 5'd0; x.p2 = 1'b0; x.o3 = 5'd0; x.p3 = 1'b0;
        end else begin
            x.p2 = s.sw2 && ($countones(s.e2) >= 3);
            x.o2 = s.sw2 ? s.e2 : 5'd0;
            if (s.l2_off4) x.o2 = x.o2 & 5'b11101;
            x.p3 = (s.sw3a || s.sw3b) && ($countones(s.e3) >= 2);
            x.o3 = (s.sw3a || s.sw3b) ? s.e3 : 5'd0;
            if (s.l3_off3) x.o3 = x.o3 & 5'b11011;
            if (s.l3_off4) x.o3 = x.o3 & 5'b11101;
        end
        return x;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; r = s.r; e1 = s.e1; e2 = s.e2; e3 = s.e3;
        sw2 = s.sw2; l2_off4 = s.l2_off4; sw3a = s.sw3a; sw3b = s.sw3b;
        l3_off3 = s.l3_off3; l3_off4 = s.l3_off4;
    endtask

    // Drive at the falling edge, expect the result just after the next rising edge.
    task automatic apply(input stim_t s);
        drive(s);
        exp_q.push_back(model(s, s.rst));
        @(negedge clk);
    endtask

    // Assert reset between edges and expect the registered outputs to clear at once.
    task automatic mid_reset(input stim_t s);
        #2;
        s.rst = 1'b1;
        drive(s);
        exp_q.push_back(model(s, 1'b1));
        ->mon_ev;
        exp_q.push_back(model(s, 1'b1));
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk or mon_ev);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("o1", o1, x.o1);
                chk("level1_passed", {4'd0, level1_passed}, {4'd0, x.p1});
                chk("o2", o2, x.o2);
                chk("level2_passed", {4'd0, level2_passed}, {4'd0, x.p2});
                chk("o3", o3, x.o3);
                chk("level3_passed", {4'd0, level3_passed}, {4'd0, x.p3});
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    wait_cyc;
        s = '{rst: 1'b1, r: 5'b10101, e1: 5'b11110, e2: 5'b11100, e3: 5'd0,
              sw2: 1'b1, l2_off4: 1'b0, sw3a: 1'b0, sw3b: 1'b0, l3_off3: 1'b0, l3_off4: 1'b0};
        apply(s);
        apply(s);
        s.e1 = 5'b11100;
        apply(s);
        s.rst = 1'b0;
        apply(s);
        s.l2_off4 = 1'b1;
        apply(s);
        s.l2_off4 = 1'b0; s.e2 = 5'b11000;
        apply(s);
        s.sw2 = 1'b0; s.e2 = 5'b11111;
        apply(s);
        s.sw3a = 1'b1; s.e3 = 5'b11000; s.l3_off3 = 1'b1; s.l3_off4 = 1'b1;
        apply(s);
        s.e3 = 5'b10000;
        apply(s);
        s.sw3a = 1'b0; s.sw3b = 1'b1; s.e3 = 5'b11110; s.l3_off4 = 1'b0;
        apply(s);
        mid_reset(s);
        s.rst = 1'b0;
        apply(s);
        s.l3_off3 = 1'b0;
        apply(s);

        for (int i = 0; i < 300; i++) begin
            s.rst     = ($urandom_range(0, 15) == 0);
            s.r       = 5'($urandom); s.e1 = 5'($urandom);
            s.e2      = 5'($urandom); s.e3 = 5'($urandom);
            s.sw2     = 1'($urandom); s.l2_off4 = 1'($urandom);
            s.sw3a    = 1'($urandom); s.sw3b    = 1'($urandom);
            s.l3_off3 = 1'($urandom); s.l3_off4 = 1'($urandom);
            if (!s.rst && $urandom_range(0, 24) == 0) mid_reset(s);
            else apply(s);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
